// File: rtl/icache_model_param.sv
// ----------------------------------------------------------------------------
// icache_model_param
//   Behavioural instruction-cache stand-in for CPU front-end bring-up.
//   Returns FETCH_WIDTH consecutive 32-bit words per fetch from a loadable
//   ROM. It models a one-entry line tag, so a fetch outside the current line
//   pays a programmable refill latency. Outputs are registered and honour
//   stall and flush.
//
// Ports
//   clk              rising-edge clock
//   rstn             asynchronous reset, active low
//   flush            synchronous clear of outputs; aborts a refill
//   stall            holds ir_reg / valid_mask_reg / icache_valid_reg
//   pc               fetch address (pc[1:0] ignored)
//   wr_en            ROM load strobe
//   wr_addr          ROM word index
//   wr_data          ROM word
//   icache_valid_reg output registers hold a valid fetch group
//   ir_reg           lane k (bits 32k+31:32k) = instruction at pc+4k
//   valid_mask_reg   lane k valid iff it lies in the aligned group of pc
//   miss_cnt         misses taken since reset (wraps)
// ----------------------------------------------------------------------------
module icache_model_param #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          DEPTH       = 256,
  parameter int          LINE_BYTES  = 16,
  parameter int          MISS_LAT    = 3,
  parameter logic [31:0] FILL_INST   = 32'h0280_0000
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic                        stall,
  input  logic [31:0]                 pc,
  input  logic                        wr_en,
  input  logic [$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [31:0]                 wr_data,
  output logic                        icache_valid_reg,
  output logic [32*FETCH_WIDTH-1:0]   ir_reg,
  output logic [FETCH_WIDTH-1:0]      valid_mask_reg,
  output logic [31:0]                 miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LB = $clog2(LINE_BYTES);
  localparam int TW = 32 - LB;
  localparam int CW = (MISS_LAT > 2) ? $clog2(MISS_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MISS_LAT > 0) ? MISS_LAT - 1 : 0);

  typedef enum logic {ST_RUN, ST_REFILL} state_t;

  logic [31:0] rom [DEPTH];

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [TW-1:0]             tag_q, tag_d;
  logic                      tag_vld_q, tag_vld_d;
  logic                      vld_q, vld_d;
  logic [32*FETCH_WIDTH-1:0] ir_q, ir_d;
  logic [FETCH_WIDTH-1:0]    mask_q, mask_d;
  logic [31:0]               miss_cnt_q, miss_cnt_d;

  logic [TW-1:0]             line;
  logic                      hit;
  logic [29:0]               word_off;
  logic [29:0]               lane_word [FETCH_WIDTH];
  logic [32*FETCH_WIDTH-1:0] lane_data;
  logic [FETCH_WIDTH-1:0]    lane_mask;
  logic                      unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];

  assign line     = pc[31:LB];
  assign hit      = tag_vld_q && (tag_q == line);
  // Offset of pc inside its aligned fetch group; lanes past the group end are masked.
  assign word_off = pc[31:2] & 30'(FETCH_WIDTH - 1);

  // Lane read is combinational from the ROM, so a same-cycle write is not seen.
  always_comb begin
    lane_data = '0;
    lane_mask = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_word[k] = pc[31:2] + 30'(k);
      if (lane_word[k] < 30'(DEPTH)) lane_data[32*k +: 32] = rom[lane_word[k][AW-1:0]];
      else                           lane_data[32*k +: 32] = FILL_INST;
      lane_mask[k] = (word_off + 30'(k)) < 30'(FETCH_WIDTH);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    tag_vld_d  = tag_vld_q;
    vld_d      = vld_q;
    ir_d       = ir_q;
    mask_d     = mask_q;
    miss_cnt_d = miss_cnt_q;

    if (state_q == ST_RUN) begin
      if (flush) begin
        vld_d  = 1'b0;
        ir_d   = '0;
        mask_d = '0;
      end else if (hit || (MISS_LAT == 0)) begin
        if (!stall) begin
          vld_d  = 1'b1;
          ir_d   = lane_data;
          mask_d = lane_mask;
        end
      end else begin
        state_d    = ST_REFILL;
        cnt_d      = CNT_INIT;
        miss_cnt_d = miss_cnt_q + 32'd1;
        if (!stall) vld_d = 1'b0;
      end
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (flush) begin
        state_d   = ST_RUN;
        tag_vld_d = 1'b0;
        vld_d     = 1'b0;
        ir_d      = '0;
        mask_d    = '0;
      end else begin
        if (!stall) vld_d = 1'b0;
        // Refill finishes on the edge where the counter reaches zero; the tag
        // captures whatever line pc points at now.
        if (cnt_q <= CW'(1)) begin
          state_d   = ST_RUN;
          tag_d     = line;
          tag_vld_d = 1'b1;
        end
      end
    end

    if (wr_en) tag_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      tag_q      <= '0;
      tag_vld_q  <= 1'b0;
      vld_q      <= 1'b0;
      ir_q       <= '0;
      mask_q     <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      tag_vld_q  <= tag_vld_d;
      vld_q      <= vld_d;
      ir_q       <= ir_d;
      mask_q     <= mask_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // ROM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) rom[wr_addr] <= wr_data;
  end

  assign icache_valid_reg = vld_q;
  assign ir_reg           = ir_q;
  assign valid_mask_reg   = mask_q;
  assign miss_cnt         = miss_cnt_q;

endmodule

// File: tb/tb_icache_model_param.sv
// ----------------------------------------------------------------------------
// tb_icache_model_param
//   Directed bench for icache_model_param. Two instances share all inputs:
//   dut0 with MISS_LAT=0 (always hits) and dut with MISS_LAT=3.
// ----------------------------------------------------------------------------
module tb_icache_model_param;

  localparam logic [31:0] A    = 32'h1111_0000;
  localparam logic [31:0] B    = 32'h1111_0001;
  localparam logic [31:0] C    = 32'h1111_0002;
  localparam logic [31:0] D    = 32'h1111_0003;
  localparam logic [31:0] E    = 32'hEEEE_0001;
  localparam logic [31:0] Z    = 32'hFFFF_00FF;
  localparam logic [31:0] FILL = 32'h0280_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        stall;
  logic [31:0] pc;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  logic        v0, v3;
  logic [63:0] ir0, ir3;
  logic [1:0]  m0, m3;
  logic [31:0] mc0, mc3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icache_model_param #(.FETCH_WIDTH(2), .DEPTH(256), .LINE_BYTES(16), .MISS_LAT(0),
                       .FILL_INST(FILL)) dut0 (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall), .pc(pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .icache_valid_reg(v0), .ir_reg(ir0), .valid_mask_reg(m0), .miss_cnt(mc0));

  icache_model_param #(.FETCH_WIDTH(2), .DEPTH(256), .LINE_BYTES(16), .MISS_LAT(3),
                       .FILL_INST(FILL)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall), .pc(pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .icache_valid_reg(v3), .ir_reg(ir3), .valid_mask_reg(m3), .miss_cnt(mc3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_wr(input logic [7:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; stall = 1'b0; pc = 32'd0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #2;
    chk("rst_valid", {63'd0, v3}, 64'd0);
    chk("rst_ir", ir3, 64'd0);
    chk("rst_mask", {62'd0, m3}, 64'd0);
    chk("rst_miss_cnt", {32'd0, mc3}, 64'd0);
    chk("rst_valid0", {63'd0, v0}, 64'd0);

    // ROM load while held in reset
    rom_wr(8'd0, A); rom_wr(8'd1, B); rom_wr(8'd2, C); rom_wr(8'd3, D);
    rom_wr(8'd4, 32'h2222_0000); rom_wr(8'd5, 32'h2222_0001);
    rom_wr(8'd8, 32'h3333_0000); rom_wr(8'd9, 32'h3333_0001);
    rom_wr(8'd255, Z);
    rstn = 1'b1;

    // Edge 1: always-hit instance returns {B,A}; latency model misses.
    pc = 32'd0;
    tick();
    chk("t1_ir_pc0", ir0, {B, A});
    chk("t1_mask_pc0", {62'd0, m0}, 64'd3);
    chk("t1_valid_pc0", {63'd0, v0}, 64'd1);
    chk("t2_miss_valid_e1", {63'd0, v3}, 64'd0);
    chk("t2_miss_cnt_e1", {32'd0, mc3}, 64'd1);
    tick();
    chk("t2_valid_e2", {63'd0, v3}, 64'd0);
    tick();
    chk("t2_valid_e3", {63'd0, v3}, 64'd0);
    tick();
    chk("t2_valid_e4", {63'd0, v3}, 64'd1);
    chk("t2_ir_e4", ir3, {B, A});
    chk("t2_mask_e4", {62'd0, m3}, 64'd3);
    chk("t2_miss_cnt_e4", {32'd0, mc3}, 64'd1);

    // pc=4: odd half of the group, only lane 0 valid
    pc = 32'd4;
    tick();
    chk("t1_ir_pc4", ir0, {C, B});
    chk("t1_mask_pc4", {62'd0, m0}, 64'd1);
    chk("t2_hit_ir_pc4", ir3, {C, B});
    chk("t2_hit_mask_pc4", {62'd0, m3}, 64'd1);

    // pc=8: same line, hits on the next edge
    pc = 32'd8;
    tick();
    chk("t2_hit_valid_pc8", {63'd0, v3}, 64'd1);
    chk("t2_hit_ir_pc8", ir3, {64'h0000_0000_0000_0000} | {D, C});
    chk("t2_hit_mask_pc8", {62'd0, m3}, 64'd3);
    chk("t2_hit_miss_cnt", {32'd0, mc3}, 64'd1);

    // Test 3: new line under a 5-cycle stall; outputs frozen
    pc = 32'd16;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_ir", ir3, {D, C});
      chk("t3_stall_valid", {63'd0, v3}, 64'd1);
    end
    chk("t3_miss_cnt_stall", {32'd0, mc3}, 64'd2);
    stall = 1'b0;
    tick();
    chk("t3_release_valid", {63'd0, v3}, 64'd1);
    chk("t3_release_ir", ir3, {32'h2222_0001, 32'h2222_0000});
    chk("t3_release_mask", {62'd0, m3}, 64'd3);
    chk("t3_miss_cnt", {32'd0, mc3}, 64'd2);

    // Test 4: flush on the second edge of a miss
    pc = 32'd32;
    tick();
    chk("t4_miss_cnt_e1", {32'd0, mc3}, 64'd3);
    chk("t4_valid_e1", {63'd0, v3}, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_valid", {63'd0, v3}, 64'd0);
    chk("t4_flush_ir", ir3, 64'd0);
    chk("t4_flush_mask", {62'd0, m3}, 64'd0);
    chk("t4_flush_miss_cnt", {32'd0, mc3}, 64'd3);
    tick();
    chk("t4_remiss_cnt", {32'd0, mc3}, 64'd4);
    tick();
    tick();
    chk("t4_remiss_valid_e3", {63'd0, v3}, 64'd0);
    tick();
    chk("t4_remiss_valid_e4", {63'd0, v3}, 64'd1);
    chk("t4_remiss_ir", ir3, {32'h3333_0001, 32'h3333_0000});

    // Test 5: last ROM word; lane 1 falls past the ROM
    pc = 32'd1020;
    tick(); tick(); tick(); tick();
    chk("t5_valid", {63'd0, v3}, 64'd1);
    chk("t5_ir", ir3, {FILL, Z});
    chk("t5_mask", {62'd0, m3}, 64'd1);
    chk("t5_miss_cnt", {32'd0, mc3}, 64'd5);

    // Test 6: write during a hit returns old data, then forces a miss
    pc = 32'd0;
    tick(); tick(); tick(); tick();
    chk("t6_pre_ir", ir3, {B, A});
    chk("t6_pre_miss_cnt", {32'd0, mc3}, 64'd6);
    tick();
    rom_wr(8'd1, E);
    chk("t6_wr_old_ir", ir3, {B, A});
    chk("t6_wr_old_valid", {63'd0, v3}, 64'd1);
    tick();
    chk("t6_miss_valid", {63'd0, v3}, 64'd0);
    chk("t6_miss_cnt", {32'd0, mc3}, 64'd7);
    tick(); tick();
    chk("t6_refill_valid", {63'd0, v3}, 64'd0);
    tick();
    chk("t6_new_valid", {63'd0, v3}, 64'd1);
    chk("t6_new_ir", ir3, {E, A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
